// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: default widths, the skid
// depth and the reader state encoding.
package fifo_pkg;

  localparam int FIFO_DATA_W     = 8;
  localparam int FIFO_SKID_DEPTH = 2;
  localparam int FIFO_CNT_W      = 16;

  // IDLE  : nothing held and no read outstanding
  // FETCH : a read strobe was issued, its word arrives next cycle
  // HOLD  : words are parked in the skid buffer with no read outstanding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } reader_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order holding buffer between the FIFO read port and the
// downstream stream. Entry 0 is always the head; entry 1 is the tail.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] entry0_q, entry0_d;
  logic [DATA_W-1:0] entry1_q, entry1_d;
  logic [1:0]        occ_q, occ_d;

  // The reader never pushes into a full buffer unless it also pops, so only
  // the reachable push/pop/occupancy combinations need real handling.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) entry0_d = push_data;
        else               entry1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        occ_d    = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          entry0_d = push_data;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy; cleared so the stream output reads zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

  assign head = entry0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO (one-cycle read latency) into a valid/ready
// stream, using a two-entry skid buffer so no word is lost under stalls.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int SKID_DEPTH = FIFO_SKID_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rd_en,
  input  logic [DATA_W-1:0]     buf_out,
  input  logic                  buf_empty,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [FIFO_CNT_W-1:0] words_read,
  output logic                  busy
);

  reader_state_e         state_q, state_d;
  logic                  started_q;
  logic [FIFO_CNT_W-1:0] words_read_q;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            held;
  logic [2:0]            limit;

  // A read strobe is issued only when the word it fetches is guaranteed a
  // skid slot, counting what is held, what is in flight and what leaves now.
  always_comb begin
    inflight  = (state_q == FETCH);
    out_valid = (occ != 2'd0);
    pop       = out_valid && out_ready;
    held      = {1'b0, occ} + {2'b00, inflight};
    limit     = 3'(SKID_DEPTH) + {2'b00, pop};
    rd_en     = started_q && en && !buf_empty && (held < limit);
    occ_next  = occ + {1'b0, inflight} - {1'b0, pop};
    busy      = inflight || out_valid;
  end

  // Next state: FETCH whenever a read goes out, HOLD while words remain
  // parked, otherwise back to IDLE.
  always_comb begin
    if (rd_en)                  state_d = FETCH;
    else if (occ_next != 2'd0)  state_d = HOLD;
    else                        state_d = IDLE;
  end

  // Reader FSM, post-reset read gate and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      started_q    <= 1'b0;
      words_read_q <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (pop) words_read_q <= words_read_q + 1'b1;
    end
  end

  assign words_read = words_read_q;

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (buf_out),
    .pop       (pop),
    .head      (out_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a queue-based FIFO and stream model
// predicts every output each cycle; directed tables and sequences cover the
// drain, backpressure, throughput, enable-drop, reset and wrap cases.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst, en, rdEn, bufEmpty, outValid, outReady, busy;
  logic [7:0]  bufOut, outData;
  logic [15:0] wordsRead;

  int total = 0;
  int bad   = 0;

  // Model state: words still in the FIFO, and words fetched but not yet
  // accepted downstream (held in flight or in the skid buffer).
  logic [7:0]  fifoQ[$];
  logic [7:0]  streamQ[$];
  bit          lastRd, fresh;
  logic [15:0] expWords;

  // DUT values sampled in the most recent step.
  logic        smpRd, smpValid, smpBusy;
  logic [7:0]  smpData;
  logic [15:0] smpWords;

  typedef struct {
    bit          en;
    bit          ready;
    bit          expRd;
    bit          expValid;
    logic [7:0]  expData;
    logic [15:0] expWords;
    bit          expBusy;
  } vec_t;

  vec_t drainVec[9];

  // 10-unit clock.
  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_W     (8),
    .SKID_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rd_en      (rdEn),
    .buf_out    (bufOut),
    .buf_empty  (bufEmpty),
    .out_valid  (outValid),
    .out_data   (outData),
    .out_ready  (outReady),
    .words_read (wordsRead),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a negedge. Inputs are applied,
  // outputs are checked against the model, then the FIFO is advanced.
  task automatic applyStimulus(input bit enV, input bit readyV, input bit wrV, input logic [7:0] wrData);
    bit emptyNow, expValid, pop, expRd;
    int held;
    en       = enV;
    outReady = readyV;
    emptyNow = (fifoQ.size() == 0);
    bufEmpty = emptyNow;
    #1;
    smpRd = rdEn; smpValid = outValid; smpBusy = busy; smpData = outData; smpWords = wordsRead;
    held     = streamQ.size();
    expValid = (held - int'(lastRd)) != 0;
    pop      = expValid && readyV;
    expRd    = enV && !emptyNow && ((held - int'(pop)) < 2) && !fresh;
    checkOutput("rd_en", 32'(rdEn), 32'(expRd));
    checkOutput("out_valid", 32'(outValid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'(held != 0));
    checkOutput("words_read", 32'(wordsRead), 32'(expWords));
    checkOutput("rd_en_while_empty", 32'(rdEn & bufEmpty), 32'd0);
    if (expValid) checkOutput("out_data", 32'(outData), 32'(streamQ[0]));
    if (pop) begin
      void'(streamQ.pop_front());
      expWords++;
    end
    if (expRd) streamQ.push_back(fifoQ.pop_front());
    lastRd = expRd;
    fresh  = 1'b0;
    @(posedge clk);
    #1;
    bufOut = expRd ? streamQ[streamQ.size()-1] : 8'($urandom);
    if (wrV) fifoQ.push_back(wrData);
    @(negedge clk);
  endtask

  // Holds reset across an edge, checks the reset outputs with reads
  // otherwise enabled, and releases reset at a negedge.
  task automatic resetDut();
    rst = 1'b1; en = 1'b1; outReady = 1'b1; bufEmpty = 1'b0; bufOut = 8'hA5;
    fifoQ.delete(); streamQ.delete();
    lastRd = 1'b0; fresh = 1'b1; expWords = '0;
    @(posedge clk);
    #1;
    checkOutput("reset_rd_en", 32'(rdEn), 32'd0);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_data", 32'(outData), 32'd0);
    checkOutput("reset_words_read", 32'(wordsRead), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt, guard, written;

    drainVec[0] = '{1, 1, 0, 0, 8'h00, 16'd0, 0};
    drainVec[1] = '{1, 1, 1, 0, 8'h00, 16'd0, 0};
    drainVec[2] = '{1, 1, 1, 0, 8'h00, 16'd0, 1};
    drainVec[3] = '{1, 1, 1, 1, 8'h01, 16'd0, 1};
    drainVec[4] = '{1, 1, 1, 1, 8'h02, 16'd1, 1};
    drainVec[5] = '{1, 1, 1, 1, 8'h03, 16'd2, 1};
    drainVec[6] = '{1, 1, 0, 1, 8'h04, 16'd3, 1};
    drainVec[7] = '{1, 1, 0, 1, 8'h05, 16'd4, 1};
    drainVec[8] = '{1, 1, 0, 0, 8'h00, 16'd5, 0};

    // Basic drain of a preloaded FIFO.
    $display("[TB] basic drain");
    resetDut();
    for (int i = 1; i <= 5; i++) fifoQ.push_back(8'(i));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(drainVec[i].en, drainVec[i].ready, 1'b0, 8'h00);
      checkOutput("vec_rd_en", 32'(smpRd), 32'(drainVec[i].expRd));
      checkOutput("vec_out_valid", 32'(smpValid), 32'(drainVec[i].expValid));
      checkOutput("vec_words_read", 32'(smpWords), 32'(drainVec[i].expWords));
      checkOutput("vec_busy", 32'(smpBusy), 32'(drainVec[i].expBusy));
      if (drainVec[i].expValid) checkOutput("vec_out_data", 32'(smpData), 32'(drainVec[i].expData));
    end

    // Backpressure: downstream stalls for steps 3..7.
    $display("[TB] backpressure");
    resetDut();
    for (int i = 0; i < 8; i++) fifoQ.push_back(8'h10 + 8'(i));
    cnt = 0;
    for (int s = 0; s < 25; s++) begin
      applyStimulus(1'b1, !(s >= 3 && s <= 7), 1'b0, 8'h00);
      if (s >= 3 && s <= 7 && smpRd) cnt++;
    end
    checkOutput("bp_stall_reads_le2", 32'(cnt <= 2), 32'd1);
    checkOutput("bp_words", 32'(wordsRead), 32'd8);

    // Writer feeding an empty FIFO one word per cycle.
    $display("[TB] streaming throughput");
    resetDut();
    cnt = 0;
    guard = 0;
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, 1'b1, s < 10, 8'h40 + 8'(s));
      if (s >= 3 && s <= 12 && smpValid) cnt++;
      if (s >= 1 && s <= 10 && smpRd) guard++;
    end
    checkOutput("tp_valid_run", 32'(cnt), 32'd10);
    checkOutput("tp_read_run", 32'(guard), 32'd10);

    // Enable drops right after a read strobe.
    $display("[TB] enable drop");
    resetDut();
    for (int i = 0; i < 3; i++) fifoQ.push_back(8'h61 + 8'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("endrop_strobe", 32'(smpRd), 32'd1);
    cnt = 0;
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      if (smpRd) cnt++;
    end
    checkOutput("endrop_no_reads", 32'(cnt), 32'd0);
    checkOutput("endrop_delivered", 32'(smpWords), 32'd1);
    for (int s = 0; s < 8; s++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("endrop_total", 32'(wordsRead), 32'd3);

    // Reset pulsed mid-stream with both skid entries occupied.
    $display("[TB] mid-operation reset");
    resetDut();
    for (int i = 0; i < 6; i++) fifoQ.push_back(8'h80 + 8'(i));
    for (int s = 0; s < 5; s++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("mid_pre_valid", 32'(outValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_out_valid", 32'(outValid), 32'd0);
    checkOutput("mid_words_read", 32'(wordsRead), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_rd_en", 32'(rdEn), 32'd0);
    checkOutput("mid_out_data", 32'(outData), 32'd0);
    @(negedge clk);
    resetDut();
    for (int i = 0; i < 4; i++) fifoQ.push_back(8'hC0 + 8'(i));
    for (int s = 0; s < 10; s++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("mid_restart_words", 32'(wordsRead), 32'd4);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    resetDut();
    for (int s = 0; s < 400; s++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1, 8'($urandom));
    for (int s = 0; s < 12; s++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

    // Counter wrap after 65535 deliveries.
    $display("[TB] counter wrap");
    resetDut();
    written = 0;
    guard = 0;
    while (expWords != 16'hFFFF && guard < 66000) begin
      applyStimulus(1'b1, 1'b1, written < 65536, 8'(written));
      if (written < 65536) written++;
      guard++;
    end
    checkOutput("wrap_reached", 32'(expWords), 32'h0000FFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_at_max", 32'(smpWords), 32'h0000FFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_to_zero", 32'(smpWords), 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning FIFO word width.
REQ-002 SHALL have parameter SKID_DEPTH, default 2, meaning output holding entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  drain enable.
REQ-006 SHALL have port rd_en  output  1  FIFO read strobe.
REQ-007 SHALL have port buf_out  input  DATA_W  FIFO read data, valid one cycle after an accepted rd_en.
REQ-008 SHALL have port buf_empty  input  1  FIFO empty flag.
REQ-009 SHALL have port out_valid  output  1  stream word valid.
REQ-010 SHALL have port out_data  output  DATA_W  stream word.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port words_read  output  16  count of words handed downstream.
REQ-013 SHALL have port busy  output  1  high when a read is in flight or any skid entry is occupied.

Function
REQ-014 SHALL track occ (0..2, skid entries held) and inflight (1 when rd_en was asserted in the previous cycle).
REQ-015 SHALL define pop = out_valid && out_ready; a word transfers downstream only on pop.
REQ-016 SHALL drive rd_en = en && !buf_empty && (occ + inflight - pop) < 2, combinational from registered state, buf_empty and out_ready.
REQ-017 SHALL never assert rd_en while buf_empty is high.
REQ-018 SHALL capture buf_out into the skid tail on the cycle after rd_en (inflight = 1), with no data loss under any out_ready pattern.
REQ-019 SHALL present the skid head on out_data, with out_valid = (occ != 0), in FIFO order.
REQ-020 SHALL hold out_data stable while out_valid && !out_ready.
REQ-021 SHALL sustain one word per cycle when en = 1, out_ready = 1 and the FIFO stays non-empty; first-word latency is 2 cycles from rd_en to out_valid.
REQ-022 SHALL permit a capture and a pop in the same cycle, leaving occ unchanged.
REQ-023 SHALL continue to capture an in-flight word after en is deasserted; en gates only new reads.
REQ-024 SHALL implement state machine IDLE/FETCH/HOLD with these transitions:
- IDLE: occ = 0, inflight = 0, no rd_en.
- FETCH: rd_en asserted this cycle.
- HOLD: occ + inflight = 2, or out_ready low with occ != 0.
- Return to IDLE: when all three counts (occ, inflight, rd_en) are 0.
REQ-025 SHALL increment words_read on each pop, wrapping 16'hFFFF -> 0.

Reset
REQ-026 SHALL, while rst is high, force rd_en=0, out_valid=0, out_data=0, words_read=0, busy=0, occ=0, inflight=0, state=IDLE, independent of clk.
REQ-027 SHALL discard any in-flight read on reset assertion mid-operation; the FIFO is reset by the same rst.
REQ-028 SHALL assert no rd_en on the first posedge after rst deasserts.

Structure
REQ-029 SHALL take DATA_W, SKID_DEPTH, the 16-bit count width and the state enum (IDLE, FETCH, HOLD) from shared package fifo_pkg.
REQ-030 SHALL place the 2-entry storage plus occ bookkeeping in sub-module fifo_skid_buf (push, pop, head, occ); fifo_reader holds the rd_en logic, FSM and counter.

Verification
REQ-031 SHALL cover basic drain: FIFO preloaded with 8'h01..8'h05, en=1, out_ready=1 -> out_data 01..05 on 5 consecutive cycles, the first 2 cycles after the first rd_en; words_read=5; rd_en never high with buf_empty.
REQ-032 SHALL cover backpressure: 8 words, out_ready low for cycles 3..7 -> at most 2 rd_en pulses while stalled, out_data frozen, all 8 words delivered in order, no duplicates.
REQ-033 SHALL cover simultaneous write and read: writer pushes 1 word/cycle into an empty FIFO, out_ready=1 -> throughput 1 word/cycle after 2-cycle fill, buf_full never asserted.
REQ-034 SHALL cover en drop: en falls in the same cycle rd_en is high -> that word is still delivered; no further rd_en until en=1.
REQ-035 SHALL cover mid-operation reset: rst pulsed with occ=2 -> out_valid=0, words_read=0 immediately; the post-reset stream restarts cleanly.
REQ-036 SHALL cover counter wrap: words_read preset via 65535 pops, then one more pop -> words_read=0.
